// File: rtl/wb_arbiter2_if.sv
// if_wb: pipelined Wishbone bus bundle; master drives the request, slave returns ack/stall/data.
interface if_wb;
   logic        cyc, stb, we, ack, stall;
   logic [31:0] adr, dat_o, dat_i;
   logic [3:0]  sel;
   modport master(output cyc, stb, we, adr, sel, dat_o, input dat_i, ack, stall);
   modport slave(input cyc, stb, we, adr, sel, dat_o, output dat_i, ack, stall);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master pipelined Wishbone arbiter sharing one slave port,
// holding the grant for a whole cyc tenure and draining outstanding acks before handover.
module wb_arbiter2 #(
   parameter bit RR   = 1'b1,
   parameter int OUTW = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   if_wb.slave        m0,
   if_wb.slave        m1,
   if_wb.master       s,
   output logic [1:0] grant,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;
   localparam logic [OUTW-1:0] MAX = '1;
   state_t          state, state_nx;
   logic            last, last_nx;
   logic [OUTW-1:0] cnt, cnt_nx;
   logic            own0, own1, full, inc, dec;
   assign own0 = state == OWN0;
   assign own1 = state == OWN1;
   assign full = cnt == MAX;
   // request path is a pure mux; stb is withheld once the outstanding counter saturates
   assign s.cyc   = own0 ? m0.cyc : own1 ? m1.cyc : state == DRAIN;
   assign s.stb   = ~full & (own0 ? m0.cyc & m0.stb : own1 ? m1.cyc & m1.stb : 1'b0);
   assign s.we    = own0 ? m0.we : own1 ? m1.we : 1'b0;
   assign s.adr   = own0 ? m0.adr : own1 ? m1.adr : '0;
   assign s.sel   = own0 ? m0.sel : own1 ? m1.sel : '0;
   assign s.dat_o = own0 ? m0.dat_o : own1 ? m1.dat_o : '0;
   assign m0.ack   = own0 & s.ack;
   assign m0.dat_i = own0 ? s.dat_i : '0;
   assign m0.stall = own0 ? s.stall | full : 1'b1;
   assign m1.ack   = own1 & s.ack;
   assign m1.dat_i = own1 ? s.dat_i : '0;
   assign m1.stall = own1 ? s.stall | full : 1'b1;
   assign inc    = s.stb & ~s.stall;
   assign dec    = s.ack & (cnt != '0);
   assign cnt_nx = (inc & ~dec) ? cnt + 1'b1 : (dec & ~inc) ? cnt - 1'b1 : cnt;
   assign grant  = {own1, own0};
   assign busy   = state != IDLE;
   always_comb begin
      state_nx = state;
      last_nx  = last;
      if (state == IDLE) begin
         if (m0.cyc && (!m1.cyc || !RR || last)) begin
            state_nx = OWN0;
            last_nx  = 1'b0;
         end else if (m1.cyc) begin
            state_nx = OWN1;
            last_nx  = 1'b1;
         end
      end else if (state == DRAIN || !(own0 ? m0.cyc : m1.cyc))
         state_nx = (cnt_nx == '0) ? IDLE : DRAIN;
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
      end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed and random scenarios; a slave model returns data derived from
// the address, and a scoreboard matches forwarded acks and slave-side requests to what masters issued.
module tb_wb_arbiter2;
   typedef struct packed {logic we; logic [31:0] adr; logic [3:0] sel; logic [31:0] dat;} req_t;
   typedef struct {int due; logic [31:0] d;} pend_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [1:0] grant, fgrant;
   logic busy, fbusy;
   int n_chk = 0, n_pass = 0;
   int ncyc = 0, lat = 1, ack_budget = 1 << 30, acks0 = 0;
   bit rnd_stall = 0, rnd_lat = 0;
   logic [31:0] exp0[$], exp1[$];
   req_t req_q[$], obs_q[$];
   pend_t pend[$];
   if_wb m0_if(), m1_if(), s_if(), f0_if(), f1_if(), fs_if();
   always #5 clk = ~clk;
   wb_arbiter2 #(.RR(1'b1), .OUTW(2)) dut (.clk_i(clk), .rst_i(rst_n), .m0(m0_if), .m1(m1_if),
      .s(s_if), .grant(grant), .busy(busy));
   wb_arbiter2 #(.RR(1'b0), .OUTW(2)) dut_fp (.clk_i(clk), .rst_i(rst_n), .m0(f0_if), .m1(f1_if),
      .s(fs_if), .grant(fgrant), .busy(fbusy));
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask
   function automatic logic [31:0] resp(input logic [31:0] a);
      return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
   endfunction
   function automatic req_t rnd_req();
      req_t r;
      r.we  = 1'($urandom_range(0, 1));
      r.adr = $urandom;
      r.sel = 4'($urandom);
      r.dat = $urandom;
      return r;
   endfunction
   task automatic drive(input int i, input logic c, input logic st, input req_t r);
      if (i == 0) begin
         m0_if.cyc = c; m0_if.stb = st; m0_if.we = r.we; m0_if.adr = r.adr; m0_if.sel = r.sel; m0_if.dat_o = r.dat;
      end else begin
         m1_if.cyc = c; m1_if.stb = st; m1_if.we = r.we; m1_if.adr = r.adr; m1_if.sel = r.sel; m1_if.dat_o = r.dat;
      end
   endtask
   function automatic logic stall_of(input int i);
      return i == 0 ? m0_if.stall : m1_if.stall;
   endfunction
   function automatic int pending(input int i);
      return i == 0 ? exp0.size() : exp1.size();
   endfunction
   task automatic book(input int i, input req_t r);
      if (i == 0) exp0.push_back(resp(r.adr));
      else exp1.push_back(resp(r.adr));
      req_q.push_back(r);
   endtask
   // holds stb until the master sees stall low, then books the expected response
   task automatic issue(input int i, input req_t r);
      int n = 0;
      drive(i, 1'b1, 1'b1, r);
      @(negedge clk);
      while (stall_of(i) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("m%0d_accept", i), stall_of(i), 1'b0);
      if (!stall_of(i)) book(i, r);
      @(posedge clk); #1;
      drive(i, 1'b1, 1'b0, r);
   endtask
   task automatic wait_acks(input int i);
      int n = 0;
      while (pending(i) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("m%0d_all_acked", i), pending(i), 0);
   endtask
   task automatic release_m(input int i);
      @(posedge clk); #1;
      drive(i, 1'b0, 1'b0, '0);
   endtask
   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   task automatic tenures(input int i);
      repeat (12) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         @(posedge clk); #1;
         drive(i, 1'b1, 1'b0, '0);
         repeat ($urandom_range(1, 4)) begin
            if ($urandom_range(0, 2) == 0) begin
               @(posedge clk); #1;
            end
            issue(i, rnd_req());
         end
         wait_acks(i);
         release_m(i);
      end
   endtask
   // slave model: in-order responses, each acked no earlier than its latency after acceptance
   initial begin
      req_t o;
      s_if.ack = 1'b0; s_if.stall = 1'b0; s_if.dat_i = '0;
      forever begin
         @(negedge clk);
         if (s_if.ack && pend.size() > 0) void'(pend.pop_front());
         if (s_if.cyc && s_if.stb && !s_if.stall) begin
            pend.push_back('{ncyc + (rnd_lat ? int'($urandom_range(1, 3)) : lat), resp(s_if.adr)});
            o = {s_if.we, s_if.adr, s_if.sel, s_if.dat_o};
            obs_q.push_back(o);
         end
         @(posedge clk); #1;
         ncyc++;
         while (obs_q.size() > 0 && req_q.size() > 0) check("slave_req", obs_q.pop_front(), req_q.pop_front());
         s_if.stall = rnd_stall && $urandom_range(0, 3) == 0;
         s_if.ack = pend.size() > 0 && pend[0].due <= ncyc && ack_budget > 0;
         if (s_if.ack) ack_budget--;
         s_if.dat_i = s_if.ack ? pend[0].d : '0;
      end
   end
   // monitor: forwarded acks must match the scoreboard; non-owners must be fully isolated
   always @(negedge clk) if (rst_n) begin
      if (m0_if.ack) begin
         acks0++;
         check("m0_ack_expected", exp0.size() != 0, 1'b1);
         if (exp0.size() != 0) check("m0_ack_data", m0_if.dat_i, exp0.pop_front());
      end
      if (m1_if.ack) begin
         check("m1_ack_expected", exp1.size() != 0, 1'b1);
         if (exp1.size() != 0) check("m1_ack_data", m1_if.dat_i, exp1.pop_front());
      end
      check("m0_isolated", grant[0] || (m0_if.stall && !m0_if.ack && m0_if.dat_i == '0), 1'b1);
      check("m1_isolated", grant[1] || (m1_if.stall && !m1_if.ack && m1_if.dat_i == '0), 1'b1);
      check("grant_legal", $countones(grant) <= 1, 1'b1);
   end
   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      req_t r, z;
      int a, acc, g1, n, sa, lst, c;
      z = '0;
      drive(0, 1'b0, 1'b0, z);
      drive(1, 1'b0, 1'b0, z);
      f0_if.cyc = 0; f0_if.stb = 0; f0_if.we = 0; f0_if.adr = '0; f0_if.sel = '0; f0_if.dat_o = '0;
      f1_if.cyc = 0; f1_if.stb = 0; f1_if.we = 0; f1_if.adr = '0; f1_if.sel = '0; f1_if.dat_o = '0;
      fs_if.ack = 0; fs_if.stall = 0; fs_if.dat_i = '0;
      @(negedge clk);
      check("rst_grant", grant, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_s_ctrl", {s_if.cyc, s_if.stb, s_if.we}, 3'b000);
      check("rst_s_fields", {s_if.adr, s_if.sel, s_if.dat_o}, '0);
      check("rst_m_side", {m0_if.stall, m1_if.stall, m0_if.ack, m1_if.ack}, 4'b1100);
      @(posedge clk); #1 rst_n = 1'b1;
      // single master, four pipelined reads
      lat = 1;
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, z);
      @(negedge clk); check("t1_grant_t", grant, 2'b00);
      @(negedge clk); check("t1_grant_t1", grant, 2'b01);
      a = acks0;
      @(posedge clk); #1;
      repeat (4) begin
         r = rnd_req();
         r.we = 1'b0;
         issue(0, r);
      end
      wait_acks(0);
      check("t1_acks", acks0 - a, 4);
      release_m(0);
      @(negedge clk); check("t1_still_own", grant, 2'b01);
      @(negedge clk); check("t1_idle", {grant, busy}, 3'b000);
      check("t1_cnt", dut.cnt, 0);
      // round-robin tie straight after reset
      do_reset();
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, z); drive(1, 1'b1, 1'b0, z);
      @(negedge clk); check("t2_grant_t", grant, 2'b00);
      @(negedge clk); check("t2_m0_first", grant, 2'b01); check("t2_m1_stall_a", m1_if.stall, 1'b1);
      @(posedge clk); #1;
      issue(0, rnd_req());
      wait_acks(0);
      release_m(0);
      @(negedge clk); check("t2_rel_t", grant, 2'b01); check("t2_m1_stall_b", m1_if.stall, 1'b1);
      @(negedge clk); check("t2_rel_t1", grant, 2'b00); check("t2_m1_stall_c", m1_if.stall, 1'b1);
      @(negedge clk); check("t2_rel_t2", grant, 2'b10);
      @(posedge clk); #1;
      issue(1, rnd_req());
      wait_acks(1);
      release_m(1);
      @(negedge clk); @(negedge clk); check("t2_idle", {grant, busy}, 3'b000);
      // fixed priority: m0 re-requests immediately, m1 never wins
      @(posedge clk); #1 f0_if.cyc = 1; f1_if.cyc = 1;
      g1 = 0;
      repeat (5) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (fgrant[1]) g1++;
         end while (fgrant == 2'b00 && n < 10);
         check("t3_m0_wins", fgrant, 2'b01);
         @(posedge clk); #1 f0_if.cyc = 0;
         @(posedge clk); #1 f0_if.cyc = 1;
      end
      check("t3_m1_starved", g1, 0);
      f0_if.cyc = 0; f1_if.cyc = 0;
      // drain: m1 leaves with three requests in flight
      lat = 4;
      @(posedge clk); #1 drive(1, 1'b1, 1'b0, z);
      repeat (3) issue(1, rnd_req());
      drive(1, 1'b0, 1'b0, z);
      exp1.delete();
      @(negedge clk); check("t4_own", {grant, busy}, 3'b101);
      @(negedge clk); check("t4_drain", {grant, busy, s_if.cyc, s_if.stb}, 5'b00110);
      sa = 0; lst = -1; c = 0;
      while (busy && c < 20) begin
         if (s_if.ack) begin
            sa++;
            lst = c;
         end
         @(negedge clk);
         c++;
      end
      check("t4_acks", sa, 3);
      check("t4_idle_after_ack", c - lst, 1);
      // saturation at three outstanding
      lat = 1; ack_budget = 0; acc = 0;
      @(posedge clk); #1 r = rnd_req(); drive(0, 1'b1, 1'b1, r);
      repeat (10) begin
         @(negedge clk);
         if (!m0_if.stall) begin
            book(0, r);
            acc++;
            r = rnd_req();
         end
         @(posedge clk); #1 drive(0, 1'b1, 1'b1, r);
      end
      check("t5_sat_accepts", acc, 3);
      @(negedge clk); check("t5_sat_stall", {m0_if.stall, s_if.stb}, 2'b10);
      ack_budget = 1;
      repeat (8) begin
         @(negedge clk);
         if (!m0_if.stall) begin
            book(0, r);
            acc++;
            r = rnd_req();
         end
         @(posedge clk); #1 drive(0, 1'b1, 1'b1, r);
      end
      check("t5_one_more", acc, 4);
      drive(0, 1'b1, 1'b0, r);
      ack_budget = 1 << 30;
      wait_acks(0);
      release_m(0);
      @(negedge clk); @(negedge clk); check("t5_idle", {grant, busy}, 3'b000);
      // asynchronous reset with two transfers outstanding
      ack_budget = 0;
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, z);
      issue(0, rnd_req());
      issue(0, rnd_req());
      @(negedge clk);
      check("t6_cnt2", dut.cnt, 2);
      check("t6_pre", {grant, busy, s_if.cyc}, 4'b0111);
      #2 rst_n = 1'b0;
      #1 check("t6_async", {grant, busy, s_if.cyc, s_if.stb}, 5'b00000);
      pend.delete();
      exp0.delete();
      drive(0, 1'b0, 1'b0, z);
      @(posedge clk); #1 rst_n = 1'b1; ack_budget = 1 << 30;
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, z);
      @(negedge clk); check("t6_fresh_t", grant, 2'b00);
      @(negedge clk); check("t6_fresh_t1", grant, 2'b01);
      @(posedge clk); #1;
      issue(0, rnd_req());
      wait_acks(0);
      release_m(0);
      // random contention with random stall and latency
      rnd_stall = 1; rnd_lat = 1;
      fork
         tenures(0);
         tenures(1);
      join
      rnd_stall = 0;
      repeat (4) @(negedge clk);
      check("end_idle", {grant, busy}, 3'b000);
      check("end_req_q", req_q.size(), 0);
      check("end_obs_q", obs_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone pipelined arbiter that shares one slave port (e.g. a single-port RAM or the I/O `mmu` branch) between two requesters such as the CPU instruction and data buses. It holds a grant for the whole `cyc` tenure of the owner, tracks outstanding transfers so the slave is never handed over with acks in flight, and inserts one idle cycle between owners. It sits between the `mmu` outputs and any `if_wb` slave that has only one port.

## Interface
Parameters:
- RR, 1 — 1: round-robin between masters; 0: fixed priority, m0 wins ties.
- OUTW, 4 — width of the outstanding-transfer counter; max outstanding = 2^OUTW-1.

Ports (the `if_wb` fields used are cyc, stb, we, adr[31:0], sel[3:0], dat_o[31:0], dat_i[31:0], ack, stall):
- clk_i  in  1  system clock; only clock.
- rst_i  in  1  reset, asynchronous, active-low.
- m0  if_wb.slave  -  requester 0.
- m1  if_wb.slave  -  requester 1.
- s  if_wb.master  -  shared slave.
- grant  out  2  one-hot current owner; 00 when no owner.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN. Registers: state, last (last owner), cnt[OUTW-1:0].
- IDLE:
  - s.cyc=s.stb=0.
  - Both masters see stall=1, ack=0, dat_i=0.
  - Only m0.cyc → OWN0. Only m1.cyc → OWN1.
  - Both: if RR=1, grant the master ≠ last; if RR=0, grant m0.
  - On entering OWNx, last←x.
- OWNx:
  - s.cyc/stb/we/adr/sel/dat_o are driven combinationally from mx.
  - mx.ack=s.ack, mx.dat_i=s.dat_i, mx.stall=s.stall | (cnt==max).
  - The non-owner sees stall=1, ack=0, dat_i=0.
  - s.stb is forced to 0 while cnt==max.
- cnt update:
  - +1 when s.stb & ~s.stall (accepted request).
  - −1 when s.ack.
  - Both in the same cycle → unchanged.
  - An ack when cnt==0 is ignored (no underflow).
  - No increment at max.
- OWNx exit when mx.cyc=0:
  - If the next cnt is 0 → IDLE.
  - Otherwise → DRAIN.
- DRAIN:
  - s.cyc=1, s.stb=0. Acks are consumed and not forwarded; both masters see stall=1, ack=0.
  - → IDLE when the next cnt is 0.
- An owner's cyc deassertion is the only way to release a grant; there is no pre-emption.
- Back-to-back tenures always pass through IDLE, so both masters re-arbitrate.
- grant: 01 in OWN0, 10 in OWN1, 00 in IDLE and DRAIN.

## Timing
- Reset (rst_i=0, async):
  - state=IDLE, last=1 (so m0 wins the first RR tie), cnt=0, grant=00, busy=0.
  - s.cyc=s.stb=s.we=0; s.adr=s.dat_o=0; s.sel=0.
  - All master ack=0, stall=1.
- Reset asserted mid-transfer aborts immediately: s.cyc drops asynchronously and in-flight acks are lost by design.
- Grant latency: mx.cyc rises in IDLE at cycle t; state=OWNx at t+1; s.cyc and s.stb follow mx in cycle t+1.
- Combinational paths: mx → s request fields; s.ack/s.dat_i/s.stall → mx. No extra latency in a tenure.
- Release: mx.cyc=0 at t with cnt=0 → IDLE at t+1; a waiting master owns the slave at t+2.
- Minimum gap between tenures: 1 idle cycle.

## Test plan
- Single master: m0 issues 4 pipelined reads with slave ack 1 cycle after accept.
  - Expect grant=01 one cycle after cyc.
  - Expect 4 acks with data forwarded.
  - Expect cnt back to 0; IDLE one cycle after cyc drops.
- Simultaneous cyc, RR=1, after reset.
  - Expect m0 granted first.
  - Expect m1 granted 1 cycle after m0 releases (grant 01→00→10).
  - Expect m1 to have seen stall=1 throughout.
- RR=0, both masters request continuously with 2-cycle tenures.
  - Expect m0 to win every arbitration; m1 starves.
- Drain: m1 issues 3 requests, then drops cyc before any ack; slave acks 2 and 4 cycles later.
  - Expect state=DRAIN with s.cyc=1, s.stb=0.
  - Expect acks not forwarded to m1.
  - Expect IDLE the cycle after the last ack.
- Saturation, OUTW=2: slave never acks; m0 issues requests.
  - Expect exactly 3 accepted, then m0 sees stall=1 and s.stb=0.
  - After one ack, exactly one more request is accepted.
- Async reset mid-tenure (cnt=2).
  - Expect s.cyc=0, grant=00, busy=0 without waiting for a clock edge.
  - After release, a fresh request is granted normally.
